// File: rtl/pipe_redirect_ctrl_if.sv
// Bundle of EX/ID hazard inputs and PC/pipeline-register control outputs.
// Latency: n/a (wires only).
// Backpressure: n/a; stalls are expressed through pc_write/ifid_write.
interface pipe_redirect_ctrl_if #(
    parameter int CNT_W = 16
);
    // Pipeline status presented to the sequencer
    logic [1:0]       next_type;
    logic             ex_valid;
    logic             idex_memread;
    logic [4:0]       idex_rd;
    logic             ifid_valid;
    logic [4:0]       ifid_rs1;
    logic [4:0]       ifid_rs2;

    // Controls returned to the pipeline
    logic [1:0]       pc_sel;
    logic             pc_write;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_flush;
    logic             busy;
    logic [CNT_W-1:0] mispredict_cnt;
    logic [CNT_W-1:0] jump_cnt;

    // Pipeline side: supplies status, consumes controls
    modport master (
        output next_type, ex_valid, idex_memread, idex_rd,
               ifid_valid, ifid_rs1, ifid_rs2,
        input  pc_sel, pc_write, ifid_write, ifid_flush, idex_flush,
               busy, mispredict_cnt, jump_cnt
    );

    // Sequencer side
    modport slave (
        input  next_type, ex_valid, idex_memread, idex_rd,
               ifid_valid, ifid_rs1, ifid_rs2,
        output pc_sel, pc_write, ifid_write, ifid_flush, idex_flush,
               busy, mispredict_cnt, jump_cnt
    );
endinterface

// File: rtl/pipe_redirect_ctrl.sv
// Pipeline sequencer: PC select, write enables, flushes, redirect statistics.
// Latency: controls are combinational (Mealy) from state+inputs; counters update one edge later.
// Backpressure: load-use hazard holds PC and IF/ID for exactly one cycle and bubbles ID/EX.
module pipe_redirect_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    pipe_redirect_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_STALL   = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] mis_cnt_q, mis_cnt_d;
    logic [CNT_W-1:0] jmp_cnt_q, jmp_cnt_d;

    logic redir;
    logic predict_ok;
    logic hz;

    // Redirect decode and load-use hazard detection
    always_comb begin
        redir      = bus.ex_valid & bus.next_type[1];
        predict_ok = bus.ex_valid & (bus.next_type == 2'b01);
        hz         = bus.ifid_valid & bus.idex_memread & (bus.idex_rd != 5'd0) &
                     ((bus.idex_rd == bus.ifid_rs1) | (bus.idex_rd == bus.ifid_rs2));
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: redirect wins over a stall; STALL/RECOVER last one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:    state_d = ST_RUN;
            ST_RUN: begin
                if (redir) begin
                    state_d = ST_RECOVER;
                end else if (hz) begin
                    state_d = ST_STALL;
                end
            end
            ST_STALL:   state_d = ST_RUN;
            ST_RECOVER: state_d = ST_RUN;
            default:    state_d = ST_INIT;
        endcase
    end

    // Output logic: defaults advance the pipeline, RUN overrides per event
    always_comb begin
        bus.pc_sel     = 2'b00;
        bus.pc_write   = 1'b1;
        bus.ifid_write = 1'b1;
        bus.ifid_flush = 1'b0;
        bus.idex_flush = 1'b0;
        bus.busy       = (state_q != ST_RUN);
        case (state_q)
            ST_INIT: begin
                bus.pc_write   = 1'b0;
                bus.ifid_flush = 1'b1;
                bus.idex_flush = 1'b1;
            end
            ST_RUN: begin
                if (redir) begin
                    bus.pc_sel     = bus.next_type;
                    bus.ifid_flush = 1'b1;
                    bus.idex_flush = 1'b1;
                end else begin
                    if (predict_ok) begin
                        bus.pc_sel = 2'b01;
                    end
                    if (hz) begin
                        bus.pc_write   = 1'b0;
                        bus.ifid_write = 1'b0;
                        bus.idex_flush = 1'b1;
                    end
                end
            end
            default: begin
                // STALL and RECOVER: pipeline advances normally, inputs ignored
            end
        endcase
    end

    // Saturating redirect counters, only counted from RUN
    always_comb begin
        mis_cnt_d = mis_cnt_q;
        jmp_cnt_d = jmp_cnt_q;
        if ((state_q == ST_RUN) && redir) begin
            if (!bus.next_type[0]) begin
                if (mis_cnt_q != CNT_MAX) begin
                    mis_cnt_d = mis_cnt_q + 1'b1;
                end
            end else begin
                if (jmp_cnt_q != CNT_MAX) begin
                    jmp_cnt_d = jmp_cnt_q + 1'b1;
                end
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mis_cnt_q <= '0;
            jmp_cnt_q <= '0;
        end else begin
            mis_cnt_q <= mis_cnt_d;
            jmp_cnt_q <= jmp_cnt_d;
        end
    end

    // Counter outputs
    always_comb begin
        bus.mispredict_cnt = mis_cnt_q;
        bus.jump_cnt       = jmp_cnt_q;
    end

endmodule

// File: tb/tb_pipe_redirect_ctrl.sv
// Directed-vector bench for pipe_redirect_ctrl.
// Latency: checks combinational controls 1ns after inputs change, mid clock low phase.
// Backpressure: n/a.
module tb_pipe_redirect_ctrl;

    logic clk;
    logic rstn;

    pipe_redirect_ctrl_if #(.CNT_W(16)) b16();
    pipe_redirect_ctrl_if #(.CNT_W(4))  b4();

    pipe_redirect_ctrl #(.CNT_W(16)) dut16 (.clk(clk), .rstn(rstn), .bus(b16));
    // Narrow-counter copy sharing the same stimulus, so saturation is reachable quickly
    pipe_redirect_ctrl #(.CNT_W(4))  dut4  (.clk(clk), .rstn(rstn), .bus(b4));

    assign b4.next_type    = b16.next_type;
    assign b4.ex_valid     = b16.ex_valid;
    assign b4.idex_memread = b16.idex_memread;
    assign b4.idex_rd      = b16.idex_rd;
    assign b4.ifid_valid   = b16.ifid_valid;
    assign b4.ifid_rs1     = b16.ifid_rs1;
    assign b4.ifid_rs2     = b16.ifid_rs2;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic [1:0]  nt;
        logic        mr;
        logic [4:0]  rd;
        logic        iv;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  ctl;   // {pc_sel, pc_write, ifid_write, ifid_flush, idex_flush, busy}
        logic [15:0] mis;
        logic [15:0] jmp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec  = 0;
    int   n_fail = 0;

    function automatic vec_t mk(logic ev, logic [1:0] nt, logic mr, logic [4:0] rd,
                                logic iv, logic [4:0] rs1, logic [4:0] rs2,
                                logic [6:0] ctl, logic [15:0] mis, logic [15:0] jmp);
        vec_t v;
        v.ev = ev; v.nt = nt; v.mr = mr; v.rd = rd; v.iv = iv;
        v.rs1 = rs1; v.rs2 = rs2; v.ctl = ctl; v.mis = mis; v.jmp = jmp;
        return v;
    endfunction

    task automatic drive(logic ev, logic [1:0] nt, logic mr, logic [4:0] rd,
                         logic iv, logic [4:0] rs1, logic [4:0] rs2);
        b16.ex_valid     = ev;
        b16.next_type    = nt;
        b16.idex_memread = mr;
        b16.idex_rd      = rd;
        b16.ifid_valid   = iv;
        b16.ifid_rs1     = rs1;
        b16.ifid_rs2     = rs2;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ctl16();
        return {b16.pc_sel, b16.pc_write, b16.ifid_write,
                b16.ifid_flush, b16.idex_flush, b16.busy};
    endfunction

    initial begin
        // ctl field layout: {sel[1:0], pw, iw, ifl, xfl, busy}
        vecs.push_back(mk(0, 2'b00, 0, 5'd0, 0, 5'd0, 5'd0, 7'b00_0_1_1_1_1, 16'd0, 16'd0)); // INIT
        vecs.push_back(mk(0, 2'b00, 0, 5'd0, 0, 5'd0, 5'd0, 7'b00_1_1_0_0_0, 16'd0, 16'd0)); // RUN idle
        vecs.push_back(mk(1, 2'b10, 0, 5'd0, 0, 5'd0, 5'd0, 7'b10_1_1_1_1_0, 16'd0, 16'd0)); // mispredict
        vecs.push_back(mk(1, 2'b10, 0, 5'd0, 0, 5'd0, 5'd0, 7'b00_1_1_0_0_1, 16'd1, 16'd0)); // RECOVER ignores
        vecs.push_back(mk(0, 2'b00, 0, 5'd0, 0, 5'd0, 5'd0, 7'b00_1_1_0_0_0, 16'd1, 16'd0));
        vecs.push_back(mk(1, 2'b01, 0, 5'd0, 0, 5'd0, 5'd0, 7'b01_1_1_0_0_0, 16'd1, 16'd0)); // predicted ok
        vecs.push_back(mk(0, 2'b10, 0, 5'd0, 0, 5'd0, 5'd0, 7'b00_1_1_0_0_0, 16'd1, 16'd0)); // ev=0 no redir
        vecs.push_back(mk(0, 2'b11, 0, 5'd0, 0, 5'd0, 5'd0, 7'b00_1_1_0_0_0, 16'd1, 16'd0));
        vecs.push_back(mk(0, 2'b00, 1, 5'd5, 1, 5'd0, 5'd5, 7'b00_0_0_0_1_0, 16'd1, 16'd0)); // hz via rs2
        vecs.push_back(mk(0, 2'b00, 1, 5'd5, 1, 5'd0, 5'd5, 7'b00_1_1_0_0_1, 16'd1, 16'd0)); // STALL once
        vecs.push_back(mk(0, 2'b00, 1, 5'd0, 1, 5'd0, 5'd0, 7'b00_1_1_0_0_0, 16'd1, 16'd0)); // rd=0 no hz
        vecs.push_back(mk(0, 2'b00, 1, 5'd7, 0, 5'd7, 5'd0, 7'b00_1_1_0_0_0, 16'd1, 16'd0)); // ifid invalid
        vecs.push_back(mk(0, 2'b00, 1, 5'd7, 1, 5'd7, 5'd3, 7'b00_0_0_0_1_0, 16'd1, 16'd0)); // hz via rs1
        vecs.push_back(mk(0, 2'b00, 0, 5'd0, 0, 5'd0, 5'd0, 7'b00_1_1_0_0_1, 16'd1, 16'd0)); // STALL
        vecs.push_back(mk(1, 2'b11, 1, 5'd5, 1, 5'd0, 5'd5, 7'b11_1_1_1_1_0, 16'd1, 16'd0)); // jump beats hz
        vecs.push_back(mk(0, 2'b00, 1, 5'd5, 1, 5'd0, 5'd5, 7'b00_1_1_0_0_1, 16'd1, 16'd1)); // RECOVER ignores hz
        vecs.push_back(mk(0, 2'b00, 0, 5'd0, 0, 5'd0, 5'd0, 7'b00_1_1_0_0_0, 16'd1, 16'd1));
        vecs.push_back(mk(0, 2'b00, 1, 5'd3, 1, 5'd4, 5'd2, 7'b00_1_1_0_0_0, 16'd1, 16'd1)); // no reg match
        vecs.push_back(mk(1, 2'b11, 0, 5'd0, 0, 5'd0, 5'd0, 7'b11_1_1_1_1_0, 16'd1, 16'd1)); // jump
        vecs.push_back(mk(0, 2'b00, 0, 5'd0, 0, 5'd0, 5'd0, 7'b00_1_1_0_0_1, 16'd1, 16'd2));
        vecs.push_back(mk(0, 2'b00, 0, 5'd0, 0, 5'd0, 5'd0, 7'b00_1_1_0_0_0, 16'd1, 16'd2));

        rstn = 1'b0;
        drive(0, 2'b00, 0, 5'd0, 0, 5'd0, 5'd0);
        repeat (2) @(negedge clk);
        #1;
        check("reset_ctl", 32'(ctl16()), 32'(7'b00_0_1_1_1_1));
        check("reset_mis", 32'(b16.mispredict_cnt), 32'd0);
        check("reset_jmp", 32'(b16.jump_cnt), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].ev, vecs[i].nt, vecs[i].mr, vecs[i].rd,
                  vecs[i].iv, vecs[i].rs1, vecs[i].rs2);
            #1;
            check($sformatf("vec%0d_ctl", i), 32'(ctl16()),             32'(vecs[i].ctl));
            check($sformatf("vec%0d_mis", i), 32'(b16.mispredict_cnt),  32'(vecs[i].mis));
            check($sformatf("vec%0d_jmp", i), 32'(b16.jump_cnt),        32'(vecs[i].jmp));
            @(negedge clk);
        end

        // Saturation: 13 more jumps bring the counters from 2 to 15
        for (int k = 0; k < 13; k++) begin
            drive(1, 2'b11, 0, 5'd0, 0, 5'd0, 5'd0);
            @(negedge clk);
            drive(0, 2'b00, 0, 5'd0, 0, 5'd0, 5'd0);
            @(negedge clk);
        end
        #1;
        check("sat_pre_narrow", 32'(b4.jump_cnt),  32'd15);
        check("sat_pre_wide",   32'(b16.jump_cnt), 32'd15);
        @(negedge clk);
        drive(1, 2'b11, 0, 5'd0, 0, 5'd0, 5'd0);
        #1;
        check("sat_jump_sel", 32'(b4.pc_sel), 32'd3);
        @(negedge clk);
        drive(0, 2'b00, 0, 5'd0, 0, 5'd0, 5'd0);
        #1;
        check("sat_hold_narrow", 32'(b4.jump_cnt),       32'd15);
        check("sat_wide_incr",   32'(b16.jump_cnt),      32'd16);
        check("sat_mis_narrow",  32'(b4.mispredict_cnt), 32'd1);
        check("sat_recover_bz",  32'(b4.busy),           32'd1);
        @(negedge clk);

        // Reset asserted during STALL
        drive(0, 2'b00, 1, 5'd9, 1, 5'd9, 5'd0);
        #1;
        check("pre_stall_pw", 32'(b16.pc_write), 32'd0);
        @(negedge clk);
        drive(0, 2'b00, 0, 5'd0, 0, 5'd0, 5'd0);
        #1;
        check("stall_ctl", 32'(ctl16()), 32'(7'b00_1_1_0_0_1));
        #1;
        rstn = 1'b0;
        #1;
        check("midrst_ctl",  32'(ctl16()),             32'(7'b00_0_1_1_1_1));
        check("midrst_jmp",  32'(b16.jump_cnt),        32'd0);
        check("midrst_mis",  32'(b16.mispredict_cnt),  32'd0);
        check("midrst_jmp4", 32'(b4.jump_cnt),         32'd0);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        check("post_rst_init", 32'(ctl16()), 32'(7'b00_0_1_1_1_1));
        @(negedge clk);
        #1;
        check("post_rst_run", 32'(ctl16()), 32'(7'b00_1_1_0_0_0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
